// File: rtl/icon_pkg.sv
// -----------------------------------------------------------------------------
// icon_pkg
// Shared constants for the RojoBot icon pipeline: visible-area geometry (also
// used by draw_icon and the VGA timing block), the position-controller state
// encoding, and a small clamp helper.
// -----------------------------------------------------------------------------
package icon_pkg;

  localparam int unsigned V_ACTIVE    = 480;
  localparam int unsigned H_ACTIVE    = 640;
  localparam int unsigned ICON_WIDTH  = 15;
  localparam int unsigned ICON_HEIGHT = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    COMMIT = 2'd2
  } pos_state_e;

  // Unsigned 10-bit saturate: returns lim whenever v exceeds it.
  function automatic logic [9:0] clampCoord(input logic [9:0] v, input logic [9:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/icon_pos_ctrl_if.sv
// -----------------------------------------------------------------------------
// icon_pos_ctrl_if
// Valid/ready location-update channel from the bot-side logic to the icon
// position controller.
//   upd_valid : request from the master
//   upd_x     : requested X (10 bits)
//   upd_y     : requested Y (9 bits)
//   upd_ready : slave can accept this cycle
// -----------------------------------------------------------------------------
interface icon_pos_ctrl_if;

  logic       upd_valid;
  logic [9:0] upd_x;
  logic [8:0] upd_y;
  logic       upd_ready;

  modport master (output upd_valid, output upd_x, output upd_y, input upd_ready);
  modport slave  (input upd_valid, input upd_x, input upd_y, output upd_ready);

endinterface

// File: rtl/vblank_edge.sv
// -----------------------------------------------------------------------------
// vblank_edge
// Detects the first cycle of vertical blank from the current scan line.
// Reusable by any frame-synchronous block.
//   clk, reset : pixel clock, async active-high reset
//   vert_i     : current scan line
//   edge_o     : high for the single cycle where vert first reaches V_ACTIVE
// -----------------------------------------------------------------------------
module vblank_edge #(
  parameter int unsigned V_ACTIVE = icon_pkg::V_ACTIVE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] vert_i,
  output logic       edge_o
);

  localparam logic [9:0] VB_START = 10'(V_ACTIVE);

  logic vbNow;
  logic vb_q;

  assign vbNow = (vert_i >= VB_START);

  // Delayed vblank resets to 1 so releasing reset inside vblank does not
  // produce a spurious edge for that partial frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vb_q <= 1'b1;
    end else begin
      vb_q <= vbNow;
    end
  end

  assign edge_o = vbNow & ~vb_q;

endmodule

// File: rtl/icon_pos_ctrl.sv
// -----------------------------------------------------------------------------
// icon_pos_ctrl
// Frame-synchronous icon position controller. Location updates are accepted
// over a valid/ready channel, clamped to the visible area, held in a shadow
// register and committed to bot_LocX/bot_LocY only at the start of vblank, so
// the icon never tears. Also produces a frame tick and a wrapping frame count.
//   clk, reset  : pixel clock, async active-high reset
//   vert, horz  : scan position from VGA timing (horz is not used)
//   upd         : update channel (slave side)
//   bot_LocX/Y  : committed position for draw_icon
//   upd_pending : shadow holds an uncommitted update
//   frame_tick  : one-cycle pulse the cycle after each vblank edge
//   frame_cnt   : 8-bit wrapping frame counter
// -----------------------------------------------------------------------------
module icon_pos_ctrl
  import icon_pkg::*;
#(
  parameter int unsigned V_ACTIVE    = icon_pkg::V_ACTIVE,
  parameter int unsigned H_ACTIVE    = icon_pkg::H_ACTIVE,
  parameter int unsigned ICON_WIDTH  = icon_pkg::ICON_WIDTH,
  parameter int unsigned ICON_HEIGHT = icon_pkg::ICON_HEIGHT,
  parameter int unsigned RESET_X     = 312,
  parameter int unsigned RESET_Y     = 232
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [9:0]            vert,
  input  logic [9:0]            horz,
  icon_pos_ctrl_if.slave        upd,
  output logic [9:0]            bot_LocX,
  output logic [8:0]            bot_LocY,
  output logic                  upd_pending,
  output logic                  frame_tick,
  output logic [7:0]            frame_cnt
);

  localparam logic [9:0] X_MAX   = 10'(H_ACTIVE - ICON_WIDTH);
  localparam logic [9:0] Y_MAX   = 10'(V_ACTIVE - ICON_HEIGHT);
  localparam logic [9:0] X_RESET = 10'(RESET_X);
  localparam logic [8:0] Y_RESET = 9'(RESET_Y);

  pos_state_e state_q, state_d;
  logic [9:0] shadowX_q, shadowX_d;
  logic [8:0] shadowY_q, shadowY_d;
  logic [9:0] locX_q, locX_d;
  logic [8:0] locY_q, locY_d;
  logic       pending_q, pending_d;
  logic       tick_q;
  logic [7:0] frameCnt_q;
  logic       vbEdge;
  logic       accept;
  logic       unused_horz;

  assign unused_horz = ^horz;

  vblank_edge #(.V_ACTIVE(V_ACTIVE)) u_vblank_edge (
    .clk    (clk),
    .reset  (reset),
    .vert_i (vert),
    .edge_o (vbEdge)
  );

  // Ready depends on the state register alone, so there is no combinational
  // path from upd_valid back to upd_ready.
  assign upd.upd_ready = (state_q != COMMIT);
  assign accept        = upd.upd_valid & upd.upd_ready;

  // Next-state logic. An accept that coincides with the edge goes straight to
  // COMMIT with the fresh value; repeated accepts before the edge overwrite the
  // shadow so only the latest one is committed.
  always_comb begin
    state_d   = state_q;
    shadowX_d = shadowX_q;
    shadowY_d = shadowY_q;
    locX_d    = locX_q;
    locY_d    = locY_q;

    if (accept) begin
      shadowX_d = clampCoord(upd.upd_x, X_MAX);
      shadowY_d = 9'(clampCoord({1'b0, upd.upd_y}, Y_MAX));
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = vbEdge ? COMMIT : PEND;
        end
      end
      PEND: begin
        if (vbEdge) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        locX_d  = shadowX_q;
        locY_d  = shadowY_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    pending_d = (state_d == PEND) || (state_d == COMMIT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      shadowX_q  <= X_RESET;
      shadowY_q  <= Y_RESET;
      locX_q     <= X_RESET;
      locY_q     <= Y_RESET;
      pending_q  <= 1'b0;
      tick_q     <= 1'b0;
      frameCnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      shadowX_q <= shadowX_d;
      shadowY_q <= shadowY_d;
      locX_q    <= locX_d;
      locY_q    <= locY_d;
      pending_q <= pending_d;
      tick_q    <= vbEdge;
      if (vbEdge) begin
        frameCnt_q <= frameCnt_q + 8'd1;
      end
    end
  end

  assign bot_LocX    = locX_q;
  assign bot_LocY    = locY_q;
  assign upd_pending = pending_q;
  assign frame_tick  = tick_q;
  assign frame_cnt   = frameCnt_q;

endmodule

// File: doc/icon_pos_ctrl.md
# icon_pos_ctrl

Frame-synchronous position controller for the RojoBot icon. Accepts location updates from the bot-side logic through a valid/ready handshake, holds them in a shadow register, clamps them to the visible area, and commits them to the `draw_icon` position inputs only at the start of vertical blank. This guarantees the icon never tears mid-frame. It also provides a one-cycle frame tick and a wrapping frame counter for motion pacing.

## Interface
Parameters:
- `V_ACTIVE`, 480: first non-visible line; vblank is `vert >= V_ACTIVE`.
- `H_ACTIVE`, 640: visible width.
- `ICON_WIDTH`, 15: icon width in pixels.
- `ICON_HEIGHT`, 15: icon height in pixels.
- `RESET_X`, 312: `bot_LocX` value after reset.
- `RESET_Y`, 232: `bot_LocY` value after reset.

Ports:
- `clk`, in, 1: pixel-domain clock.
- `reset`, in, 1: asynchronous, active-high.
- `vert`, in, 10: current scan line from the VGA timing block.
- `horz`, in, 10: current pixel column. Unused except for lint pass-through.
- `upd_valid`, in, 1: update request.
- `upd_x`, in, 10: requested X.
- `upd_y`, in, 9: requested Y.
- `upd_ready`, out, 1: request accepted when `upd_valid & upd_ready`.
- `bot_LocX`, out, 10: committed X, drives `draw_icon`.
- `bot_LocY`, out, 9: committed Y, drives `draw_icon`.
- `upd_pending`, out, 1: the shadow register holds an uncommitted update.
- `frame_tick`, out, 1: one-cycle pulse per frame.
- `frame_cnt`, out, 8: frame counter that wraps.

## Operation
- vblank edge: `vb = (vert >= V_ACTIVE)`. `vb_d` is a register that resets to 1. `edge = vb & ~vb_d`. No edge fires in the first frame if reset is released inside vblank.
- Clamp at accept:
  - `sx = min(upd_x, H_ACTIVE-ICON_WIDTH)`, which is 625 with defaults.
  - `sy = min(upd_y, V_ACTIVE-ICON_HEIGHT)`, which is 465 with defaults.
  - Comparisons are unsigned at 10-bit width. `upd_y` is zero-extended before comparison.
- States:
  - IDLE: no pending update.
  - PEND: shadow loaded, waiting for an edge.
  - COMMIT: one cycle; copies the shadow to `bot_LocX`/`bot_LocY`.
- Transitions:
  - IDLE, accept, no edge → PEND.
  - IDLE or PEND, accept with edge in the same cycle → COMMIT. The newly accepted value is used.
  - PEND, edge, no accept → COMMIT.
  - PEND, accept, no edge → PEND. The shadow is overwritten: latest wins, and the earlier value is dropped.
  - COMMIT → IDLE unconditionally.
  - IDLE, edge, no accept → IDLE. Outputs are unchanged.
- `upd_ready = (state != COMMIT)`. It is combinational from the state register only.
- `upd_pending = (state == PEND) | (state == COMMIT)`.
- `frame_tick`: registered; high the cycle after each edge, independent of state.
- `frame_cnt`: increments on each edge and wraps from 255 to 0.
- Reset values: state IDLE, `bot_LocX`=`RESET_X`, `bot_LocY`=`RESET_Y`, shadow = reset position, `frame_tick`=0, `frame_cnt`=0, `upd_pending`=0, `vb_d`=1. `upd_ready`=1 during and after reset.
- Reset mid-operation discards any pending shadow. The position returns to `RESET_X`/`RESET_Y` immediately, because reset is asynchronous.

## Timing
- Edge detected in cycle N with PEND or a simultaneous accept: state is COMMIT in N+1, and the new `bot_LocX`/`bot_LocY` are visible from N+2.
- `frame_tick` is high only in N+1.
- An accept in cycle N with no edge: `upd_pending` is high from N+1.
- Commit always lands inside vblank. Vblank spans 45 lines, far more than 2 cycles, so there is no active-line write.
- Maximum one commit per frame. Updates arriving faster than the frame rate are coalesced: the last accepted value before the edge wins.
- All outputs are registered except `upd_ready`.

## Structure
- Shared package `icon_pkg`:
  - `V_ACTIVE`, `H_ACTIVE`, `ICON_WIDTH`, `ICON_HEIGHT` constants, shared with `draw_icon` and the VGA timing block.
  - State encoding localparams: IDLE=2'd0, PEND=2'd1, COMMIT=2'd2.
- Sub-module `vblank_edge`: contains the `vb`/`vb_d` register and the edge output. It is reusable by other frame-synchronous blocks.
- Top-level: FSM, shadow registers, clamp logic, frame counter.

## Test plan
- Reset check: assert `reset` with `vert`=100 and `upd_valid`=1.
  - `bot_LocX`=312, `bot_LocY`=232, `upd_ready`=1, `frame_cnt`=0, `upd_pending`=0.
  - After release, no `frame_tick` until `vert` first crosses 479→480.
- Basic commit: accept (100,50) at `vert`=200.
  - `upd_pending`=1 and `bot_Loc` unchanged through line 479.
  - When `vert` hits 480 at cycle N, `bot_Loc`=(100,50) from N+2. `upd_pending` drops at N+2 and `frame_tick`=1 at N+1.
- Coalescing: accept (10,10), then (20,20), then (30,30) within one frame.
  - Only (30,30) is committed.
  - Exactly one commit at the edge.
- Clamp: accept (700,500) → commits (625,465). Accept (625,465) → unchanged.
- Simultaneous: accept (40,60) in the same cycle as the edge, from IDLE.
  - COMMIT next cycle, `bot_Loc`=(40,60) two cycles after the edge.
  - A `upd_valid` held during COMMIT is stalled (`upd_ready`=0) and accepted the following cycle into PEND.
- Wrap and reset mid-flight: run 256 frames → `frame_cnt` wraps to 0. Then accept an update, assert `reset` before the edge → no commit; position returns to (312,232).
